// File: rtl/reg_acc_pkg.sv
// Shared definitions for the reg_acc_stack accumulator: command encoding and
// default parameter values.
package reg_acc_pkg;

    localparam int              DEF_WIDTH = 16;
    localparam int              DEF_DEPTH = 4;
    localparam longint unsigned DEF_STEP  = 1;

    typedef enum logic [2:0] {
        CMD_HOLD,
        CMD_POP,
        CMD_MUX,
        CMD_ALU,
        CMD_INC,
        CMD_CLR,
        CMD_DEC
    } cmd_e;

endpackage

// File: rtl/acc_lifo.sv
// DEPTH x WIDTH save/restore stack. The caller only presents legal,
// mutually exclusive push/pop requests; all error handling lives in the top.
module acc_lifo
    import reg_acc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_top,
    output logic             o_full,
    output logic             o_empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic [PW-1:0]    w_wr_idx;
    logic [PW-1:0]    w_rd_idx;

    assign w_wr_idx = PW'(r_count);
    assign w_rd_idx = PW'(r_count - CW'(1));

    // NOTE: non-blocking assignments for every sequential register, so all
    // flops sample pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_push) begin
            r_count <= r_count + CW'(1);
        end else if (i_pop) begin
            r_count <= r_count - CW'(1);
        end
    end

    // NOTE: storage array has no reset; only the occupancy count qualifies it.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[w_wr_idx] <= i_data;
        end
    end

    assign o_top   = r_mem[w_rd_idx];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/reg_acc_stack.sv
// Accumulator register with prioritised load/inc/dec/clear and a save/restore
// stack. Define REG_ACC_SAT_EN to saturate inc/dec instead of wrapping.
module reg_acc_stack
    import reg_acc_pkg::*;
#(
    parameter int              WIDTH = DEF_WIDTH,
    parameter int              DEPTH = DEF_DEPTH,
    parameter longint unsigned STEP  = DEF_STEP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mux_load,
    input  logic             alu_load,
    input  logic             inc,
    input  logic             clear,
    input  logic             dec,
    input  logic             push,
    input  logic             pop,
    input  logic             ovf_clr,
    input  logic [WIDTH-1:0] mux_in,
    input  logic [WIDTH-1:0] alu_in,
    output logic [WIDTH-1:0] data_out,
    output logic             zero,
    output logic             ovf,
    output logic             stk_full,
    output logic             stk_empty,
    output logic             stk_err
);

    logic [WIDTH-1:0] r_data;
    logic             r_ovf;
    logic             r_stk_err;

    logic             w_full;
    logic             w_empty;
    logic [WIDTH-1:0] w_top;
    logic             w_push_ok;
    logic             w_pop_ok;
    logic             w_stk_err_set;
    logic             w_ovf_set;
    cmd_e             w_cmd;
    logic [WIDTH:0]   w_step;
    logic [WIDTH:0]   w_inc_full;
    logic [WIDTH:0]   w_dec_full;
    logic [WIDTH-1:0] w_next;

    // An illegal request leaves the stack alone; data path then ignores pop.
    assign w_push_ok     = push & ~pop & ~w_full;
    assign w_pop_ok      = pop & ~push & ~w_empty;
    assign w_stk_err_set = (push & pop) | (push & w_full) | (pop & w_empty);

    acc_lifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_lifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push_ok),
        .i_pop   (w_pop_ok),
        .i_data  (r_data),
        .o_top   (w_top),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // NOTE: default assigned first so no path through the block infers a latch.
    always_comb begin
        w_cmd = CMD_HOLD;
        if (w_pop_ok)      w_cmd = CMD_POP;
        else if (mux_load) w_cmd = CMD_MUX;
        else if (alu_load) w_cmd = CMD_ALU;
        else if (inc)      w_cmd = CMD_INC;
        else if (clear)    w_cmd = CMD_CLR;
        else if (dec)      w_cmd = CMD_DEC;
    end

    assign w_step     = (WIDTH + 1)'(STEP);
    assign w_inc_full = {1'b0, r_data} + w_step;
    assign w_dec_full = {1'b0, r_data} - w_step;

    always_comb begin
        w_next    = r_data;
        w_ovf_set = 1'b0;
        case (w_cmd)
            CMD_POP: w_next = w_top;
            CMD_MUX: w_next = mux_in;
            CMD_ALU: w_next = alu_in;
            CMD_CLR: w_next = '0;
            CMD_INC: begin
                w_ovf_set = w_inc_full[WIDTH];
`ifdef REG_ACC_SAT_EN
                w_next = w_inc_full[WIDTH] ? '1 : w_inc_full[WIDTH-1:0];
`else
                w_next = w_inc_full[WIDTH-1:0];
`endif
            end
            CMD_DEC: begin
                w_ovf_set = w_dec_full[WIDTH];
`ifdef REG_ACC_SAT_EN
                w_next = w_dec_full[WIDTH] ? '0 : w_dec_full[WIDTH-1:0];
`else
                w_next = w_dec_full[WIDTH-1:0];
`endif
            end
            default: w_next = r_data;
        endcase
    end

    // Set conditions outrank ovf_clr for each sticky flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data    <= '0;
            r_ovf     <= 1'b0;
            r_stk_err <= 1'b0;
        end else begin
            r_data <= w_next;
            if (w_ovf_set)          r_ovf <= 1'b1;
            else if (ovf_clr)       r_ovf <= 1'b0;
            if (w_stk_err_set)      r_stk_err <= 1'b1;
            else if (ovf_clr)       r_stk_err <= 1'b0;
        end
    end

    assign data_out  = r_data;
    assign zero      = (r_data == '0);
    assign ovf       = r_ovf;
    assign stk_full  = w_full;
    assign stk_empty = w_empty;
    assign stk_err   = r_stk_err;

endmodule

// File: doc/reg_acc_stack.md
REG_ACC_STACK -- requirements
Module: reg_acc_stack

Interface
REQ-001 Parameter WIDTH, default 16, accumulator and data-path width in bits (legal 2..64).
REQ-002 Parameter DEPTH, default 4, save/restore stack entries (legal 1..16).
REQ-003 Parameter STEP, default 1, magnitude added by inc / subtracted by dec (legal 1..2**WIDTH-1).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 mux_load  in  1  load data_out from mux_in.
REQ-007 alu_load  in  1  load data_out from alu_in.
REQ-008 inc / clear / dec  in  1 each  add STEP / load zero / subtract STEP.
REQ-009 push  in  1  save current data_out onto stack.
REQ-010 pop  in  1  restore top of stack into data_out.
REQ-011 ovf_clr  in  1  clear sticky flags ovf and stk_err.
REQ-012 mux_in, alu_in  in  WIDTH  load sources.
REQ-013 data_out  out  WIDTH  accumulator value (registered).
REQ-014 zero  out  1  high iff data_out == 0 (combinational from data_out).
REQ-015 ovf  out  1  sticky: inc/dec crossed range boundary.
REQ-016 stk_full, stk_empty  out  1 each  stack occupancy == DEPTH / == 0.
REQ-017 stk_err  out  1  sticky: illegal stack operation.

Function
REQ-018 Data update priority per cycle SHALL be: valid pop > mux_load > alu_load > inc > clear > dec > hold; latency one cycle.
REQ-019 Valid pop (pop=1, push=0, not empty) SHALL load data_out with top entry and decrement occupancy.
REQ-020 Valid push (push=1, pop=0, not full) SHALL store pre-edge data_out and increment occupancy; data op of same cycle proceeds per REQ-018.
REQ-021 Push when full, pop when empty, or push and pop together SHALL leave the stack unchanged, set stk_err, and let data_out follow REQ-018 ignoring pop.
REQ-022 inc SHALL compute data_out+STEP in WIDTH+1 bits; carry-out sets ovf; dec with borrow sets ovf.
REQ-023 Without saturation (REQ-028), overflowing inc/dec SHALL wrap modulo 2**WIDTH.
REQ-024 ovf/stk_err set condition SHALL win over ovf_clr in the same cycle; otherwise ovf_clr clears both next edge.
REQ-025 Loads (mux/alu/pop) and clear SHALL never affect ovf.

Reset
REQ-026 rst_n low SHALL immediately force data_out=0, occupancy=0, ovf=0, stk_err=0; hence zero=1, stk_empty=1, stk_full=0; stack contents not reset.
REQ-027 Reset asserted mid-operation SHALL discard any in-flight push/pop; first post-reset edge behaves as from empty.

Configuration
REQ-028 Macro REG_ACC_SAT_EN defined: overflowing inc SHALL hold 2**WIDTH-1 and underflowing dec SHALL hold 0, ovf still set; undefined: wrap per REQ-023.

Structure
REQ-029 Package reg_acc_pkg SHALL hold the command enum (CMD_HOLD, CMD_POP, CMD_MUX, CMD_ALU, CMD_INC, CMD_CLR, CMD_DEC) and default parameter constants.
REQ-030 Stack SHALL be a sub-module acc_lifo (DEPTH x WIDTH, push/pop/full/empty); priority decode and arithmetic stay in top.

Verification
REQ-031 Reset, then mux_load=1, mux_in=16'h1234, alu_load=1 same cycle -> data_out=16'h1234 next edge, zero=0.
REQ-032 data_out=16'hFFFF, inc -> 16'h0000, ovf=1, zero=1; with REG_ACC_SAT_EN -> 16'hFFFF, ovf=1.
REQ-033 Load 5, push; load 9, push; pop -> data_out=9; pop -> 5, stk_empty=1; third pop -> stk_err=1, data_out=5.
REQ-034 DEPTH=4: five pushes -> stk_full=1 after fourth, stk_err=1 after fifth; four pops return values in LIFO order.
REQ-035 push=pop=1 with inc -> stack unchanged, stk_err=1, data_out incremented by STEP; ovf_clr with no new error -> flags 0.
REQ-036 rst_n low mid-cycle with occupancy 2, data_out=16'h00AA -> data_out=0, stk_empty=1 without clock edge.
